// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur game datapath.
// Provides the game-state enum, the compositor colours and the
// visible-area geometry used by the judge and its helpers.
package dino_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [11:0] COL_BG  = 12'hFFF;
   localparam logic [11:0] COL_FG  = 12'h555;
   localparam logic [11:0] COL_HIT = 12'hF00;

   localparam int H_VISIBLE = 640;
   localparam int V_VISIBLE = 480;

   // True when the scan address lies inside the 640x480 active picture.
   function automatic logic in_visible(input logic [8:0] row, input logic [9:0] col);
      return (row < 9'(V_VISIBLE)) && (col < 10'(H_VISIBLE));
   endfunction

endpackage

// File: rtl/bcd_counter4.sv
// 4-digit BCD up-counter with synchronous clear and saturation at 9999.
// Ports:
//   clk    in   clock, rising edge
//   RESET  in   synchronous active-high reset (q -> 0)
//   clr    in   synchronous clear (q -> 0)
//   inc    in   add one (BCD carry), ignored once q is 9999
//   q      out  16-bit BCD value, digit 3 in q[15:12]
module bcd_counter4
   import dino_pkg::*;
(
   input  logic        clk,
   input  logic        RESET,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] q
);

   // Ripple a carry through the four nibbles; a 9 becomes 0 and passes
   // the carry on, anything else absorbs it.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (RESET) begin
         q <= 16'h0000;
      end else if (clr) begin
         q <= 16'h0000;
      end else if (inc && (q != 16'h9999)) begin
         q <= bcd_inc(q);
      end
   end

endmodule

// File: rtl/game_judge.sv
// Game judge: composites sprite pixels into RGB, detects dinosaur/cactus
// overlap and runs the IDLE/RUN/OVER game FSM with score and speed.
// Ports:
//   clk, RESET               pixel clock, synchronous active-high reset
//   START                    start/restart button level (debounced)
//   fresh                    frame strobe, falling edge = end of frame
//   row_addr, col_addr       current scan address
//   px_dino/cactus/ground    sprite pixel bits for this address
//   game_status, game_over   decoded RUN / OVER state
//   speed                    scroll speed, pixels per frame
//   score                    4-digit BCD score
//   rgb                      registered 4:4:4 pixel (1-cycle latency)
module game_judge
   import dino_pkg::*;
#(
   parameter int SCORE_DIV    = 6,
   parameter int SPEED_FRAMES = 600,
   parameter int SPEED_INIT   = 2,
   parameter int SPEED_MAX    = 15
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        START,
   input  logic        fresh,
   input  logic [8:0]  row_addr,
   input  logic [9:0]  col_addr,
   input  logic        px_dino,
   input  logic        px_cactus,
   input  logic        px_ground,
   output logic        game_status,
   output logic        game_over,
   output logic [3:0]  speed,
   output logic [15:0] score,
   output logic [11:0] rgb
);

   localparam int SC_W = $clog2(SCORE_DIV + 1);
   localparam int SP_W = $clog2(SPEED_FRAMES + 1);
   localparam logic [3:0] SPD_INIT = 4'(SPEED_INIT);
   localparam logic [3:0] SPD_MAX  = 4'(SPEED_MAX);

   state_t            state_q, state_d;
   logic              fresh_d, start_d;
   logic              frame_end, start_rise;
   logic              hit_q;
   logic              enter_run, advance, score_inc;
   logic              visible;
   logic [SC_W-1:0]   score_cnt;
   logic [SP_W-1:0]   speed_cnt;
   logic [11:0]       rgb_d;

   assign frame_end  = fresh_d & ~fresh;
   assign start_rise = ~start_d & START;
   assign visible    = in_visible(row_addr, col_addr);

   assign game_status = (state_q == RUN);
   assign game_over   = (state_q == OVER);

   // Next-state logic. A start edge only matters outside RUN, so a frame end
   // landing with it in IDLE/OVER is naturally ignored.
   always_comb begin
      state_d   = state_q;
      enter_run = 1'b0;
      advance   = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (start_rise) begin
               state_d   = RUN;
               enter_run = 1'b1;
            end
         end
         RUN: begin
            if (frame_end) begin
               if (hit_q) state_d = OVER;
               else       advance = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign score_inc = advance && (score_cnt == SC_W'(SCORE_DIV - 1));

   // Compositor, highest priority first.
   always_comb begin
      rgb_d = COL_BG;
      if (!visible)                           rgb_d = 12'h000;
      else if ((state_q == OVER) && px_dino)  rgb_d = COL_HIT;
      else if (px_dino | px_cactus | px_ground) rgb_d = COL_FG;
   end

   // Edge detect, FSM state and output pixel register.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q <= IDLE;
         fresh_d <= 1'b0;
         start_d <= 1'b0;
         rgb     <= 12'h000;
      end else begin
         state_q <= state_d;
         fresh_d <= fresh;
         start_d <= START;
         rgb     <= rgb_d;
      end
   end

   // Collision flag and frame counters. The flag is cleared on the same
   // frame end that samples it, so each frame judges its own overlaps.
   always_ff @(posedge clk) begin
      if (RESET) begin
         hit_q     <= 1'b0;
         score_cnt <= '0;
         speed_cnt <= '0;
         speed     <= SPD_INIT;
      end else if (enter_run) begin
         hit_q     <= 1'b0;
         score_cnt <= '0;
         speed_cnt <= '0;
         speed     <= SPD_INIT;
      end else begin
         if (frame_end)
            hit_q <= 1'b0;
         else if ((state_q == RUN) && px_dino && px_cactus && visible)
            hit_q <= 1'b1;

         if (advance) begin
            score_cnt <= score_inc ? '0 : score_cnt + 1'b1;
            if (speed_cnt == SP_W'(SPEED_FRAMES - 1)) begin
               speed_cnt <= '0;
               if (speed < SPD_MAX) speed <= speed + 4'd1;
            end else begin
               speed_cnt <= speed_cnt + 1'b1;
            end
         end
      end
   end

   bcd_counter4 u_score (
      .clk   (clk),
      .RESET (RESET),
      .clr   (enter_run),
      .inc   (score_inc),
      .q     (score)
   );

endmodule

// File: tb/tb_game_judge.sv
module tb_game_judge;

   logic        clk = 1'b0;
   logic        RESET, START, fresh;
   logic [8:0]  row_addr;
   logic [9:0]  col_addr;
   logic        px_dino, px_cactus, px_ground;

   logic        gs0, go0, gs1, go1;
   logic [3:0]  sp0, sp1;
   logic [15:0] sc0, sc1;
   logic [11:0] rgb0, rgb1;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   game_judge dut (
      .clk(clk), .RESET(RESET), .START(START), .fresh(fresh),
      .row_addr(row_addr), .col_addr(col_addr),
      .px_dino(px_dino), .px_cactus(px_cactus), .px_ground(px_ground),
      .game_status(gs0), .game_over(go0), .speed(sp0), .score(sc0), .rgb(rgb0)
   );

   game_judge #(.SCORE_DIV(1), .SPEED_FRAMES(1)) dut_s (
      .clk(clk), .RESET(RESET), .START(START), .fresh(fresh),
      .row_addr(row_addr), .col_addr(col_addr),
      .px_dino(px_dino), .px_cactus(px_cactus), .px_ground(px_ground),
      .game_status(gs1), .game_over(go1), .speed(sp1), .score(sc1), .rgb(rgb1)
   );

   // Reference model: game phase plus the number of survived frames since
   // the last start; score and speed are derived from that count.
   localparam int M_IDLE = 0, M_RUN = 1, M_OVER = 2;
   typedef struct {
      int          st;
      int          frames;
      bit          hit;
      bit          fd;
      bit          sd;
      logic [11:0] rgb;
   } mdl_t;

   mdl_t m0, m1;

   function automatic mdl_t mstep(input mdl_t m, input logic rst, input logic st_in,
                                  input logic fr, input logic [8:0] row, input logic [9:0] col,
                                  input logic d, input logic c, input logic g);
      mdl_t n;
      bit fe, sr, vis;
      n = m;
      if (rst) begin
         n.st = M_IDLE; n.frames = 0; n.hit = 0; n.fd = 0; n.sd = 0; n.rgb = 12'h000;
         return n;
      end
      fe  = m.fd && !fr;
      sr  = !m.sd && st_in;
      vis = (row < 480) && (col < 640);
      if (!vis)                    n.rgb = 12'h000;
      else if (m.st == M_OVER && d) n.rgb = 12'hF00;
      else if (d || c || g)        n.rgb = 12'h555;
      else                         n.rgb = 12'hFFF;
      if (m.st != M_RUN) begin
         if (sr) begin
            n.st = M_RUN; n.frames = 0; n.hit = 0;
         end else if (fe) begin
            n.hit = 0;
         end
      end else if (fe) begin
         if (m.hit) n.st = M_OVER;
         else       n.frames = m.frames + 1;
         n.hit = 0;
      end else if (d && c && vis) begin
         n.hit = 1;
      end
      n.fd = fr;
      n.sd = st_in;
      return n;
   endfunction

   function automatic logic [15:0] m_score(input int frames, input int div);
      int s;
      s = frames / div;
      if (s > 9999) s = 9999;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   function automatic logic [3:0] m_speed(input int frames, input int sf);
      int s;
      s = 2 + frames / sf;
      if (s > 15) s = 15;
      return 4'(s);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("m0.status", 32'(gs0),  32'(m0.st == M_RUN));
      chk("m0.over",   32'(go0),  32'(m0.st == M_OVER));
      chk("m0.speed",  32'(sp0),  32'(m_speed(m0.frames, 600)));
      chk("m0.score",  32'(sc0),  32'(m_score(m0.frames, 6)));
      chk("m0.rgb",    32'(rgb0), 32'(m0.rgb));
      chk("m1.status", 32'(gs1),  32'(m1.st == M_RUN));
      chk("m1.over",   32'(go1),  32'(m1.st == M_OVER));
      chk("m1.speed",  32'(sp1),  32'(m_speed(m1.frames, 1)));
      chk("m1.score",  32'(sc1),  32'(m_score(m1.frames, 1)));
      chk("m1.rgb",    32'(rgb1), 32'(m1.rgb));
   endtask

   // One clock: inputs already set are applied at the edge, outputs are
   // sampled 1 time unit later, and the model advances with the same inputs.
   task automatic tick();
      logic r, s, f, d, c, g;
      logic [8:0] ra;
      logic [9:0] ca;
      r = RESET; s = START; f = fresh; ra = row_addr; ca = col_addr;
      d = px_dino; c = px_cactus; g = px_ground;
      @(posedge clk);
      #1;
      m0 = mstep(m0, r, s, f, ra, ca, d, c, g);
      m1 = mstep(m1, r, s, f, ra, ca, d, c, g);
   endtask

   task automatic frame();
      fresh = 1'b1; tick();
      fresh = 1'b0; tick();
   endtask

   task automatic set_px(input logic [8:0] r, input logic [9:0] c,
                         input logic d, input logic k, input logic g);
      row_addr = r; col_addr = c; px_dino = d; px_cactus = k; px_ground = g;
   endtask

   typedef struct {
      logic [8:0]  row;
      logic [9:0]  col;
      logic        d, c, g;
      logic [11:0] exp_rgb;
   } vec_t;

   vec_t vecs[7];

   initial begin
      bit seen;
      m0 = '{default: 0};
      m1 = '{default: 0};
      RESET = 1'b1; START = 1'b0; fresh = 1'b0;
      set_px(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);

      vecs[0] = '{9'd479, 10'd639, 1'b0, 1'b0, 1'b1, 12'h555};
      vecs[1] = '{9'd480, 10'd639, 1'b0, 1'b0, 1'b1, 12'h000};
      vecs[2] = '{9'd10,  10'd640, 1'b1, 1'b0, 1'b0, 12'h000};
      vecs[3] = '{9'd0,   10'd0,   1'b0, 1'b0, 1'b0, 12'hFFF};
      vecs[4] = '{9'd200, 10'd300, 1'b0, 1'b1, 1'b0, 12'h555};
      vecs[5] = '{9'd200, 10'd300, 1'b1, 1'b1, 1'b0, 12'h555};
      vecs[6] = '{9'd511, 10'd1023, 1'b1, 1'b1, 1'b1, 12'h000};

      // Reset and idle
      tick(); tick();
      RESET = 1'b0;
      chk("rst.status", 32'(gs0), 32'd0);
      chk("rst.over",   32'(go0), 32'd0);
      chk("rst.speed",  32'(sp0), 32'd2);
      chk("rst.score",  32'(sc0), 32'h0000);
      chk("rst.rgb",    32'(rgb0), 32'h000);
      check_model();
      for (int i = 0; i < 10; i++) frame();
      chk("idle.score", 32'(sc0), 32'h0000);
      chk("idle.status", 32'(gs0), 32'd0);

      // Compositor table in IDLE
      for (int i = 0; i < 7; i++) begin
         set_px(vecs[i].row, vecs[i].col, vecs[i].d, vecs[i].c, vecs[i].g);
         tick();
         chk($sformatf("comp[%0d]", i), 32'(rgb0), 32'(vecs[i].exp_rgb));
      end
      set_px(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("idle.nohit", 32'(go0), 32'd0);

      // Start
      START = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
         tick();
         seen = (gs0 === 1'b1);
      end
      chk("start.status", 32'(seen), 32'd1);
      check_model();

      // 60 clean frames
      for (int i = 0; i < 60; i++) frame();
      chk("run60.score", 32'(sc0), 32'h0010);
      chk("run60.speed", 32'(sp0), 32'd2);
      check_model();

      // Overlap outside the visible area: no effect
      set_px(9'd380, 10'd700, 1'b1, 1'b1, 1'b0); tick();
      set_px(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      frame();
      chk("col700.status", 32'(gs0), 32'd1);
      chk("col700.score",  32'(sc0), 32'h0010);

      // Real collision
      set_px(9'd380, 10'd100, 1'b1, 1'b1, 1'b0); tick();
      set_px(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      frame();
      chk("hit.over",   32'(go0), 32'd1);
      chk("hit.status", 32'(gs0), 32'd0);
      chk("hit.score",  32'(sc0), 32'h0010);
      check_model();
      frame();
      chk("over.hold",  32'(sc0), 32'h0010);

      // Red dinosaur in OVER
      set_px(9'd100, 10'd100, 1'b1, 1'b0, 1'b0); tick();
      chk("over.rgb", 32'(rgb0), 32'hF00);
      set_px(9'd0, 10'd0, 1'b0, 1'b0, 1'b0);

      // Restart with start edge and frame end in the same cycle
      START = 1'b0; tick();
      fresh = 1'b1; tick();
      fresh = 1'b0; START = 1'b1; tick();
      chk("restart.status", 32'(gs0), 32'd1);
      chk("restart.score",  32'(sc0), 32'h0000);
      chk("restart.speed",  32'(sp0), 32'd2);
      check_model();
      for (int i = 0; i < 5; i++) tick();
      chk("held.status", 32'(gs0), 32'd1);
      chk("held.over",   32'(go0), 32'd0);

      // Saturation on the fast instance
      for (int i = 0; i < 12; i++) frame();
      chk("sat.speed12", 32'(sp1), 32'd14);
      frame();
      chk("sat.speed13", 32'(sp1), 32'd15);
      frame();
      chk("sat.speed14", 32'(sp1), 32'd15);
      for (int i = 14; i < 10001; i++) begin
         frame();
         if (i % 1000 == 999) check_model();
      end
      chk("sat.score", 32'(sc1), 32'h9999);
      chk("sat.speed", 32'(sp1), 32'd15);
      check_model();
      frame();
      chk("sat.hold", 32'(sc1), 32'h9999);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         RESET     = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) START = ~START;
         fresh     = $urandom_range(0, 1);
         row_addr  = 9'($urandom_range(0, 511));
         col_addr  = 10'($urandom_range(0, 1023));
         px_dino   = ($urandom_range(0, 7) == 0);
         px_cactus = $urandom_range(0, 1);
         px_ground = ($urandom_range(0, 3) == 0);
         tick();
         check_model();
      end

      // Reset wins over a simultaneous start edge and frame end
      RESET = 1'b0; START = 1'b0; fresh = 1'b1; tick();
      RESET = 1'b1; START = 1'b1; fresh = 1'b0; tick();
      RESET = 1'b0;
      chk("rstprio.status", 32'(gs0), 32'd0);
      chk("rstprio.score",  32'(sc0), 32'h0000);
      check_model();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
